// File: rtl/mult_div_pkg.sv
// Shared types and constants for the mult_div block.
// The state enum, the op encodings and the iteration counter width live here
// so that the top-level FSM and the divider core use the same definitions.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DFIX = 2'd3
  } stateT;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

  // The counter has to hold 0..WIDTH-1; one spare bit keeps it safe for
  // widths that are exact powers of two.
  function automatic int iterCntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int ITER_CNT_W = $clog2(DEFAULT_WIDTH) + 1;

endpackage

// File: rtl/div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step, with
// the sign fix-up applied on the outputs. Quotient truncates toward zero and
// is negated when operand signs differ; remainder follows the dividend sign.
module div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] dvsReg;
  logic             negQuo;
  logic             negRem;

  logic [WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0] dvsMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Magnitudes of the incoming operands; the most negative value maps to
  // its unsigned magnitude, which still fits in WIDTH bits.
  always_comb begin
    dvdMag = dividend[WIDTH-1] ? -dividend : dividend;
    dvsMag = divisor[WIDTH-1]  ? -divisor  : divisor;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor only if it fits.
  always_comb begin
    shifted = {remReg, quoReg[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsReg});
    diff    = shifted[WIDTH-1:0] - dvsReg;
  end

  // Partial remainder / quotient registers; the quotient register doubles as
  // the dividend shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remReg <= '0;
      quoReg <= '0;
      dvsReg <= '0;
      negQuo <= 1'b0;
      negRem <= 1'b0;
    end else if (load) begin
      remReg <= '0;
      quoReg <= dvdMag;
      dvsReg <= dvsMag;
      negQuo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negRem <= dividend[WIDTH-1];
    end else if (step) begin
      if (fits) begin
        remReg <= diff;
        quoReg <= {quoReg[WIDTH-2:0], 1'b1};
      end else begin
        remReg <= shifted[WIDTH-1:0];
        quoReg <= {quoReg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction; the top samples these in its DFIX cycle.
  always_comb begin
    quotient  = negQuo ? -quoReg : quoReg;
    remainder = negRem ? -remReg : remReg;
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply/divide unit owning the HI/LO registers.
// MULT is a radix-2 Booth multiplier, one step per cycle. DIV uses div_core
// and is only built when MULT_DIV_DIV_EN is defined; without it, every DIV
// request is answered at once with done + div_zero and HI/LO untouched.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = iterCntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  stateT              state;
  stateT              stateNext;
  logic [CNT_W-1:0]   stepCnt;

  logic [2*WIDTH+1:0] boothReg;
  logic [2*WIDTH+1:0] boothNext;
  logic [WIDTH:0]     mcand;
  logic [WIDTH:0]     boothAcc;
  logic [WIDTH:0]     boothSum;

  logic               multLoad;
  logic               multStep;
  logic               multFinish;
  logic               zeroFinish;

`ifdef MULT_DIV_DIV_EN
  logic               divLoad;
  logic               divStep;
  logic               divFinish;
  logic [WIDTH-1:0]   divQuo;
  logic [WIDTH-1:0]   divRem;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and datapath control. Requests are only honoured in IDLE,
  // so a start during an operation is silently dropped.
  always_comb begin
    stateNext  = state;
    multLoad   = 1'b0;
    multStep   = 1'b0;
    multFinish = 1'b0;
    zeroFinish = 1'b0;
`ifdef MULT_DIV_DIV_EN
    divLoad    = 1'b0;
    divStep    = 1'b0;
    divFinish  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT) begin
            stateNext = MULT;
            multLoad  = 1'b1;
          end
`ifdef MULT_DIV_DIV_EN
          else if (b != '0) begin
            stateNext = DIV;
            divLoad   = 1'b1;
          end
`endif
          else begin
            zeroFinish = 1'b1;
          end
        end
      end
      MULT: begin
        multStep = 1'b1;
        if (stepCnt == LAST_STEP) begin
          stateNext  = IDLE;
          multFinish = 1'b1;
        end
      end
`ifdef MULT_DIV_DIV_EN
      DIV: begin
        divStep = 1'b1;
        if (stepCnt == LAST_STEP) stateNext = DFIX;
      end
      DFIX: begin
        stateNext = IDLE;
        divFinish = 1'b1;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Iteration counter shared by both datapaths.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stepCnt <= '0;
`ifdef MULT_DIV_DIV_EN
    end else if (multLoad || divLoad) begin
      stepCnt <= '0;
    end else if (multStep || divStep) begin
`else
    end else if (multLoad) begin
      stepCnt <= '0;
    end else if (multStep) begin
`endif
      stepCnt <= stepCnt + CNT_W'(1);
    end
  end

  // One Booth step: inspect {q0, q-1}, add or subtract the multiplicand into
  // a WIDTH+1 bit accumulator (the spare bit absorbs the -2^(WIDTH-1) case),
  // then arithmetic-shift the whole product register right by one.
  always_comb begin
    boothAcc = boothReg[2*WIDTH+1:WIDTH+1];
    case (boothReg[1:0])
      2'b01:   boothSum = boothAcc + mcand;
      2'b10:   boothSum = boothAcc - mcand;
      default: boothSum = boothAcc;
    endcase
    boothNext = {boothSum[WIDTH], boothSum, boothReg[WIDTH:1]};
  end

  // Booth product register and latched multiplicand.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boothReg <= '0;
      mcand    <= '0;
    end else if (multLoad) begin
      boothReg <= {{(WIDTH+1){1'b0}}, a, 1'b0};
      mcand    <= {b[WIDTH-1], b};
    end else if (multStep) begin
      boothReg <= boothNext;
    end
  end

`ifdef MULT_DIV_DIV_EN
  div_core #(.WIDTH(WIDTH)) uDivCore (
    .clk       (clk),
    .reset     (reset),
    .load      (divLoad),
    .step      (divStep),
    .dividend  (a),
    .divisor   (b),
    .quotient  (divQuo),
    .remainder (divRem)
  );
`endif

  // Completion pulses and HI/LO; HI/LO only change on a successful finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
`ifdef MULT_DIV_DIV_EN
      done     <= multFinish | divFinish | zeroFinish;
`else
      done     <= multFinish | zeroFinish;
`endif
      div_zero <= zeroFinish;
      if (multFinish) begin
        hi <= boothNext[2*WIDTH:WIDTH+1];
        lo <= boothNext[WIDTH:1];
      end
`ifdef MULT_DIV_DIV_EN
      else if (divFinish) begin
        hi <= divRem;
        lo <= divQuo;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div with randomized operands and a plain
// arithmetic reference model. Adapts its DIV expectations to MULT_DIV_DIV_EN.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  typedef struct {
    int          doneAt;
    int          busyCount;
    int          dzCount;
    logic [31:0] hi;
    logic [31:0] lo;
  } expT;

  mult_div #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one request given the current HI/LO model.
  function automatic expT predict(input logic opIn, input logic [31:0] x, input logic [31:0] y);
    expT e;
    longint p;
    longint q;
    longint r;
    e.hi = modelHi;
    e.lo = modelLo;
    if (opIn == 1'b0) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.doneAt = 33; e.busyCount = 32; e.dzCount = 0;
      e.hi = p[63:32]; e.lo = p[31:0];
    end else begin
      e.doneAt = 1; e.busyCount = 0; e.dzCount = 1;
`ifdef MULT_DIV_DIV_EN
      if (y != 32'd0) begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        e.doneAt = 34; e.busyCount = 33; e.dzCount = 0;
        e.hi = r[31:0]; e.lo = q[31:0];
      end
`endif
    end
    return e;
  endfunction

  // Launch one request (start sampled at edge k) and observe the cycles that
  // follow at negedges; cycle c is the view just before edge k+c.
  task automatic applyStimulus(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                               input int extraAt, input int cycles,
                               output int doneAt, output int doneCount, output int dzCount,
                               output int dzAt, output int busyFirst, output int busyLast,
                               output int busyCount, output logic [31:0] hiAt, output logic [31:0] loAt);
    doneAt = -1; doneCount = 0; dzCount = 0; dzAt = -1;
    busyFirst = -1; busyLast = -1; busyCount = 0; hiAt = '0; loAt = '0;
    @(negedge clk);
    start = 1'b1; op = opIn; a = aIn; b = bIn;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (busy) begin
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
        busyCount++;
      end
      if (done) begin
        doneCount++;
        if (doneAt < 0) begin doneAt = c; hiAt = hi; loAt = lo; end
      end
      if (div_zero) begin
        dzCount++;
        if (dzAt < 0) dzAt = c;
      end
      if (c == extraAt) begin
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b1;
    modelHi = '0; modelLo = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_mult();
    logic [31:0] x, y;
    expT e;
    int dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt;
    logic [31:0] h, l;
    for (int i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom;
      case (i)
        0: begin x = 32'hFFFFFFFE; y = 32'h00000003; end
        1: begin x = 32'h80000000; y = 32'h80000000; end
        2: begin x = 32'h7FFFFFFF; y = 32'h80000000; end
        3: begin x = 32'h00000000; end
        default: ;
      endcase
      e = predict(1'b0, x, y);
      applyStimulus(1'b0, x, y, 0, 40, dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt, h, l);
      modelHi = e.hi; modelLo = e.lo;
      checks++; if (dAt !== e.doneAt) begin failures++; $display("FAIL mult_done_cycle[%0d]: got %0d expected %0d", i, dAt, e.doneAt); end
      checks++; if (dCnt !== 1) begin failures++; $display("FAIL mult_done_count[%0d]: got %0d expected 1", i, dCnt); end
      checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL mult_result[%0d] %h*%h: got %h_%h expected %h_%h", i, x, y, h, l, e.hi, e.lo); end
      checks++; if (bFirst !== 1 || bLast !== 32 || bCnt !== 32) begin failures++; $display("FAIL mult_busy[%0d]: got first=%0d last=%0d count=%0d expected 1 32 32", i, bFirst, bLast, bCnt); end
      checks++; if (zCnt !== 0) begin failures++; $display("FAIL mult_div_zero[%0d]: got %0d pulses expected 0", i, zCnt); end
    end
  endtask

  task automatic test_div();
    logic        o;
    logic [31:0] x, y;
    expT e;
    int dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt, expLast;
    logic [31:0] h, l;
    for (int i = 0; i < 14; i++) begin
      o = 1'b1; x = $urandom; y = $urandom;
      if (y == 32'd0) y = 32'd7;
      case (i)
        0: begin o = 1'b0; x = 32'h12345678; y = 32'h9ABCDEF0; end
        1: begin x = 32'hFFFFFFF9; y = 32'h00000002; end
        2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        3: begin y = 32'h00000000; end
        4: begin y = 32'h00000005; end
        5: begin x = 32'h00000003; y = 32'hFFFFFFF9; end
        6: begin y = 32'h00000000; x = 32'h0; end
        default: ;
      endcase
      e = predict(o, x, y);
      applyStimulus(o, x, y, 0, 40, dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt, h, l);
      modelHi = e.hi; modelLo = e.lo;
      expLast = (e.busyCount > 0) ? e.busyCount : -1;
      checks++; if (dAt !== e.doneAt) begin failures++; $display("FAIL div_done_cycle[%0d]: got %0d expected %0d", i, dAt, e.doneAt); end
      checks++; if (dCnt !== 1) begin failures++; $display("FAIL div_done_count[%0d]: got %0d expected 1", i, dCnt); end
      checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL div_result[%0d] op=%b %h,%h: got %h_%h expected %h_%h", i, o, x, y, h, l, e.hi, e.lo); end
      checks++; if (bCnt !== e.busyCount || bLast !== expLast) begin failures++; $display("FAIL div_busy[%0d]: got count=%0d last=%0d expected %0d %0d", i, bCnt, bLast, e.busyCount, expLast); end
      checks++; if (zCnt !== e.dzCount) begin failures++; $display("FAIL div_zero_count[%0d]: got %0d expected %0d", i, zCnt, e.dzCount); end
      if (e.dzCount == 1) begin
        checks++; if (zAt !== 1) begin failures++; $display("FAIL div_zero_cycle[%0d]: got %0d expected 1", i, zAt); end
        checks++; if (hi !== modelHi || lo !== modelLo) begin failures++; $display("FAIL div_zero_hilo[%0d]: got %h_%h expected %h_%h", i, hi, lo, modelHi, modelLo); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x, y;
    expT e;
    int dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt;
    logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      e = predict(1'b0, x, y);
      applyStimulus(1'b0, x, y, 5 + i, 40, dAt, dCnt, zCnt, zAt, bFirst, bLast, bCnt, h, l);
      modelHi = e.hi; modelLo = e.lo;
      checks++; if (dAt !== 33 || dCnt !== 1) begin failures++; $display("FAIL ignore_done[%0d]: got at=%0d count=%0d expected 33 1", i, dAt, dCnt); end
      checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL ignore_result[%0d]: got %h_%h expected %h_%h", i, h, l, e.hi, e.lo); end
      checks++; if (bCnt !== 32 || zCnt !== 0) begin failures++; $display("FAIL ignore_busy[%0d]: got busy=%0d dz=%0d expected 32 0", i, bCnt, zCnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, h1, l1;
    expT e1, e2;
    int firstAt, secondAt, secondCnt;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    e1 = predict(1'b0, x1, y1);
    modelHi = e1.hi; modelLo = e1.lo;
    e2 = predict(1'b0, x2, y2);
    firstAt = -1; secondAt = -1; secondCnt = 0; h1 = '0; l1 = '0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = x1; b = y1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (done && firstAt < 0) begin firstAt = c; h1 = hi; l1 = lo; end
      if (c == 33) begin start = 1'b1; op = 1'b0; a = x2; b = y2; end
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        secondCnt++;
        if (secondAt < 0) secondAt = c;
        if (c == 33) begin
          checks++; if (hi !== e2.hi || lo !== e2.lo) begin failures++; $display("FAIL b2b_second_result: got %h_%h expected %h_%h", hi, lo, e2.hi, e2.lo); end
        end
      end
    end
    modelHi = e2.hi; modelLo = e2.lo;
    checks++; if (firstAt !== 33) begin failures++; $display("FAIL b2b_first_done: got %0d expected 33", firstAt); end
    checks++; if (h1 !== e1.hi || l1 !== e1.lo) begin failures++; $display("FAIL b2b_first_result: got %h_%h expected %h_%h", h1, l1, e1.hi, e1.lo); end
    checks++; if (secondAt !== 33 || secondCnt !== 1) begin failures++; $display("FAIL b2b_second_done: got at=%0d count=%0d expected 33 1", secondAt, secondCnt); end
  endtask

  task automatic test_reset_abort();
    int doneSeen, busySeen;
    doneSeen = 0; busySeen = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    modelHi = '0; modelLo = '0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (hi !== modelHi || lo !== modelLo) begin failures++; $display("FAIL abort_hilo: got %h_%h expected %h_%h", hi, lo, modelHi, modelLo); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneSeen++;
      if (busy) busySeen++;
    end
    checks++; if (doneSeen !== 0 || busySeen !== 0) begin failures++; $display("FAIL abort_after_release: got done=%0d busy=%0d expected 0 0", doneSeen, busySeen); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
